// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and counter helper for the branch predictor
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_ctr2.sv
// rtl/bp_sat_ctr2.sv - combinational 2-bit saturating counter next-state and predict bit
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o,
  output logic       predict_o
);

  always_comb begin
    ctr_o     = ctr_next(ctr_i, taken_i);
    predict_o = ctr_i[1];
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and branch statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        predict,
  output logic [31:0] PredictedAdd,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        branch_taken,
  input  logic [31:0] BranchAdd,
  input  logic        branch_final,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [31:0] branch_q, branch_d;
  logic [31:0] mispredict_q, mispredict_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  ctr_t             upd_ctr_d;
  logic             upd_pred_unused;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup sees only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    lk_idx       = if_pc[IDX_W+1:2];
    lk_tag       = if_pc[31:IDX_W+2];
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict      = lk_hit && ctr_q[lk_idx][1];
    PredictedAdd = lk_hit ? target_q[lk_idx] : (if_pc + PC_STEP);
  end

  always_comb begin
    upd_idx = upd_pc[IDX_W+1:2];
    upd_tag = upd_pc[31:IDX_W+2];
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  bp_sat_ctr2 u_upd_ctr (
    .ctr_i     (ctr_q[upd_idx]),
    .taken_i   (branch_taken),
    .ctr_o     (upd_ctr_d),
    .predict_o (upd_pred_unused)
  );

  always_comb begin
    branch_d     = branch_q;
    mispredict_d = mispredict_q;
    if (upd_valid && (branch_q != 32'hFFFF_FFFF)) branch_d = branch_q + 32'd1;
    if (upd_valid && branch_final && (mispredict_q != 32'hFFFF_FFFF))
      mispredict_d = mispredict_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= INIT_CTR;
      end
      branch_q     <= '0;
      mispredict_q <= '0;
    end else begin
      branch_q     <= branch_d;
      mispredict_q <= mispredict_d;
      if (upd_valid) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= upd_ctr_d;
          if (branch_taken) target_q[upd_idx] <= BranchAdd;
        end else if (branch_taken) begin
          // Allocation silently evicts whatever aliased into this index.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= BranchAdd;
          ctr_q[upd_idx]    <= WT;
        end
      end
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispredict_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        predict;
  logic [31:0] PredictedAdd;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        branch_taken;
  logic [31:0] BranchAdd;
  logic        branch_final;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .INIT_CTR(2'b01)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .predict          (predict),
    .PredictedAdd     (PredictedAdd),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .branch_taken     (branch_taken),
    .BranchAdd        (BranchAdd),
    .branch_final     (branch_final),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input string tag,
                      input logic exp_pred, input logic [31:0] exp_add);
    if_pc = pc;
    #1;
    chk({tag, "_predict"}, {31'd0, predict}, {31'd0, exp_pred});
    chk({tag, "_addr"}, PredictedAdd, exp_add);
  endtask

  task automatic counts(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
    chk({tag, "_branch_count"}, branch_count, exp_b);
    chk({tag, "_mispredict_count"}, mispredict_count, exp_m);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic fin);
    upd_valid    = 1'b1;
    upd_pc       = pc;
    branch_taken = taken;
    BranchAdd    = tgt;
    branch_final = fin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid    = 1'b0;
    branch_final = 1'b0;
    rst          = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    branch_taken = 1'b0; BranchAdd = 32'h0; branch_final = 1'b0;
    @(negedge clk);
    tick();

    look(32'h100, "reset", 1'b0, 32'h104);
    counts("reset", 32'd0, 32'd0);

    upd(32'h40, 1'b1, 32'h80, 1'b1); tick();
    look(32'h40, "alloc", 1'b1, 32'h80);
    counts("alloc", 32'd1, 32'd1);

    upd(32'h40, 1'b0, 32'h0, 1'b0); tick();
    look(32'h40, "hyst_wnt", 1'b0, 32'h80);
    upd(32'h40, 1'b1, 32'h80, 1'b0); tick();
    look(32'h40, "hyst_wt", 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      upd(32'h40, 1'b1, 32'h80, 1'b0); tick();
    end
    look(32'h40, "hyst_st", 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h0, 1'b0); tick();
    look(32'h40, "hyst_st_nt", 1'b1, 32'h80);
    counts("hyst", 32'd7, 32'd1);

    look(32'h440, "alias_miss", 1'b0, 32'h444);
    upd(32'h440, 1'b1, 32'h500, 1'b1); tick();
    look(32'h40, "alias_evicted", 1'b0, 32'h44);
    look(32'h440, "alias_new", 1'b1, 32'h500);
    counts("alias", 32'd8, 32'd2);

    upd(32'h40, 1'b1, 32'h80, 1'b0); tick();
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, "rdw_same", 1'b1, 32'h80);
    tick();
    look(32'h40, "rdw_next", 1'b0, 32'h80);
    counts("rdw", 32'd10, 32'd2);

    branch_final = 1'b1; tick();
    counts("final_no_valid", 32'd10, 32'd2);

    force dut.mispredict_q = 32'hFFFF_FFFF;
    force dut.branch_q     = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_q;
    release dut.branch_q;
    upd(32'h40, 1'b0, 32'h0, 1'b1); tick();
    counts("saturate", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    upd(32'h80, 1'b1, 32'h200, 1'b1); rst = 1'b1; tick();
    look(32'h80, "rst_drop", 1'b0, 32'h84);
    look(32'h440, "rst_clear", 1'b0, 32'h444);
    look(32'h40, "rst_clear2", 1'b0, 32'h44);
    counts("rst_mid", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Supplies the IF-stage prediction, predict and PredictedAdd, that travels down the pipe to the branch comparator in EX.
- Is trained by the resolved outcome in EX: branch_taken, BranchAdd, and branch_final (the comparator's mispredict flag).
- Keeps 32-bit branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..256.
- IDX_W, log2(ENTRIES), localparam, index width.
- TAG_W, 30-IDX_W, localparam, tag width.
- INIT_CTR, 2'b01, counter value an entry holds after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- if_pc  in  32  fetch PC being looked up.
- predict  out  1  predict-taken for if_pc.
- PredictedAdd  out  32  predicted next PC for if_pc.
- upd_valid  in  1  a branch/jump resolved in EX this cycle.
- upd_pc  in  32  PC of the resolving branch.
- branch_taken  in  1  actual outcome.
- BranchAdd  in  32  actual taken target.
- branch_final  in  1  comparator mispredict flag; qualified by upd_valid.
- branch_count  out  32  number of resolved branches.
- mispredict_count  out  32  number of mispredicted branches.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- State per entry: valid, tag[TAG_W], target[32], ctr[2]. Counter encoding: 0=SNT, 1=WNT, 2=WT, 3=ST.
- Address split: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational from registered state, 0-cycle latency):
  - hit = valid[idx] && tag match.
  - predict = hit && ctr[idx][1].
  - PredictedAdd = hit ? target[idx] : if_pc+4. Add wraps mod 2^32.
- Update on rising edge when upd_valid=1, hit judged on upd_pc:
  - hit, taken: ctr = min(ctr+1, 3); target = BranchAdd.
  - hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - miss, taken: allocate (overwrites any alias): valid=1, tag, target=BranchAdd, ctr=WT.
  - miss, not taken: no change.
- Read-during-write: a lookup to the index being updated in the same cycle returns the pre-update entry. The new value is visible the next cycle; no bypass.
- Statistics:
  - branch_count +1 on each cycle with upd_valid=1.
  - mispredict_count +1 when upd_valid && branch_final.
  - Both saturate at 32'hFFFF_FFFF.
  - branch_final with upd_valid=0 is ignored.
- Reset, next edge with rst=1:
  - all valid=0, ctr=INIT_CTR, target=0.
  - branch_count=0, mispredict_count=0.
  - Any update presented in that cycle is dropped.
  - Outputs after reset: predict=0, PredictedAdd=if_pc+4. Holds when rst is asserted mid-operation.
- Synthesis: no latches; all state in one clocked always block. Lookup logic is pure combinational.

Decomposition:
- Shared package bp_pkg:
  - ctr_t typedef and the SNT/WNT/WT/ST constants.
  - PC_STEP=4.
  - ctr_next(ctr, taken) saturating function.
- One natural sub-module: bp_sat_ctr2 (combinational 2-bit counter next-state plus predict bit), instantiated in the update path.

Test Plan (ENTRIES=16; idx=pc[5:2]):
- Reset: rst=1 one cycle, then if_pc=0x100 -> predict=0, PredictedAdd=0x104, branch_count=0, mispredict_count=0.
- Allocate: upd_valid=1, upd_pc=0x40, branch_taken=1, BranchAdd=0x80, branch_final=1. Next cycle if_pc=0x40 -> predict=1, PredictedAdd=0x80, branch_count=1, mispredict_count=1.
- Hysteresis (after allocate, ctr=WT):
  - one not-taken update to 0x40 -> predict=0, PredictedAdd still 0x80 (WNT).
  - one taken -> predict=1 (WT).
  - three taken -> ST; one not-taken -> predict stays 1.
- Alias: if_pc=0x440 (idx 0, different tag) -> predict=0, PredictedAdd=0x444. Then taken update at 0x440, BranchAdd=0x500 -> 0x40 now misses, 0x440 predicts 0x500.
- Same-cycle: update to 0x40 with branch_taken=0 while if_pc=0x40 in the same cycle, entry at WT -> predict=1 that cycle, predict=0 the next cycle.
- Counter rules:
  - branch_final=1 with upd_valid=0 -> counts unchanged.
  - mispredict_count preloaded to 0xFFFF_FFFF (force) plus one mispredict -> stays 0xFFFF_FFFF.
  - rst=1 in a cycle with upd_valid=1 -> update dropped, all state cleared.
